// File: rtl/conv_job_launcher.sv
// conv_job_launcher: Avalon-MM master that programs convController.
// It latches a six-word job descriptor, writes config registers 1..6,
// writes register 0 to start the controller, then polls register 0
// until bit0 (busy) reads back 0. It also stops polling once MAX_POLLS
// busy reads have been seen, unless MAX_POLLS is 0.
//
// Bus handshake (valid/ready): m_read or m_write acts as "valid" together
// with m_address/m_writedata. !m_waitrequest acts as "ready". The master
// holds a command unchanged until a rising edge where m_waitrequest=0;
// that edge is the transfer. For reads, m_readdata is sampled on that edge.
// m_read and m_write are never high together. The bus is idle in IDLE
// and GAP.
//
// state_dbg exposes the FSM state: 0=IDLE 1=CFG 2=GO 3=GAP 4=POLL.
module conv_job_launcher #(
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 4096,
  parameter int START_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_start,
  input  logic [31:0] job_in_base,
  input  logic [31:0] job_flt_base,
  input  logic [31:0] job_out_base,
  input  logic [31:0] job_depth,
  input  logic [31:0] job_nfilt,
  input  logic [31:0] job_width,
  output logic        job_busy,
  output logic        job_done,
  output logic        job_timeout,
  output logic [2:0]  m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG  = 3'd1,
    S_GO   = 3'd2,
    S_GAP  = 3'd3,
    S_POLL = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] gap_cnt;
  logic [31:0] poll_cnt;

  // Job descriptor, frozen for the whole job.
  logic [31:0] d_in_base;
  logic [31:0] d_flt_base;
  logic [31:0] d_out_base;
  logic [31:0] d_depth;
  logic [31:0] d_nfilt;
  logic [31:0] d_width;

  logic [2:0]  next_idx;
  logic [31:0] next_word;
  logic [31:0] poll_next;
  logic        timeout_hit;
  logic        unused_readdata;

  assign state_dbg       = state;
  assign unused_readdata = ^m_readdata[31:1];

  // Select the descriptor word for the next register index.
  // Also compute the saturating poll count and the timeout condition.
  always_comb begin
    next_idx  = idx + 3'd1;
    next_word = 32'd0;
    case (next_idx)
      3'd1:    next_word = d_in_base;
      3'd2:    next_word = d_flt_base;
      3'd3:    next_word = d_out_base;
      3'd4:    next_word = d_depth;
      3'd5:    next_word = d_nfilt;
      3'd6:    next_word = d_width;
      default: next_word = 32'd0;
    endcase
    poll_next   = (poll_cnt == 32'hFFFF_FFFF) ? poll_cnt : poll_cnt + 32'd1;
    timeout_hit = (MAX_POLLS != 0) && (poll_next >= 32'(MAX_POLLS));
  end

  // Launcher FSM. All bus and status outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      gap_cnt     <= 32'd0;
      poll_cnt    <= 32'd0;
      d_in_base   <= 32'd0;
      d_flt_base  <= 32'd0;
      d_out_base  <= 32'd0;
      d_depth     <= 32'd0;
      d_nfilt     <= 32'd0;
      d_width     <= 32'd0;
      job_busy    <= 1'b0;
      job_done    <= 1'b0;
      job_timeout <= 1'b0;
      m_address   <= 3'd0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= 32'd0;
    end else begin
      job_done    <= 1'b0;
      job_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          m_read      <= 1'b0;
          m_write     <= 1'b0;
          m_address   <= 3'd0;
          m_writedata <= 32'd0;
          // A start arriving while a done/timeout pulse is visible is dropped.
          if (job_start && !job_done && !job_timeout) begin
            d_in_base   <= job_in_base;
            d_flt_base  <= job_flt_base;
            d_out_base  <= job_out_base;
            d_depth     <= job_depth;
            d_nfilt     <= job_nfilt;
            d_width     <= job_width;
            idx         <= 3'd1;
            poll_cnt    <= 32'd0;
            job_busy    <= 1'b1;
            m_write     <= 1'b1;
            m_address   <= 3'd1;
            m_writedata <= job_in_base;
            state       <= S_CFG;
          end
        end
        S_CFG: begin
          if (!m_waitrequest) begin
            if (idx == 3'd6) begin
              m_address   <= 3'd0;
              m_writedata <= 32'd0;
              state       <= S_GO;
            end else begin
              idx         <= next_idx;
              m_address   <= next_idx;
              m_writedata <= next_word;
            end
          end
        end
        S_GO: begin
          if (!m_waitrequest) begin
            m_write     <= 1'b0;
            m_address   <= 3'd0;
            m_writedata <= 32'd0;
            gap_cnt     <= 32'(START_GAP);
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == 32'd0) begin
            m_read    <= 1'b1;
            m_address <= 3'd0;
            state     <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        S_POLL: begin
          if (!m_waitrequest) begin
            m_read <= 1'b0;
            if (!m_readdata[0]) begin
              job_done <= 1'b1;
              job_busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              poll_cnt <= poll_next;
              if (timeout_hit) begin
                job_timeout <= 1'b1;
                job_busy    <= 1'b0;
                state       <= S_IDLE;
              end else begin
                gap_cnt <= 32'(POLL_GAP);
                state   <= S_GAP;
              end
            end
          end
        end
        default: begin
          m_read  <= 1'b0;
          m_write <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_launcher.sv
// Directed testbench for conv_job_launcher.
// dut_a uses short gaps and MAX_POLLS=4. dut_b uses zero gaps and no timeout.
module tb_conv_job_launcher;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] job_in_base = 0, job_flt_base = 0, job_out_base = 0;
  logic [31:0] job_depth = 0, job_nfilt = 0, job_width = 0;

  logic        job_start_a = 1'b0, m_waitrequest_a = 1'b0;
  logic        job_busy_a, job_done_a, job_timeout_a, m_read_a, m_write_a;
  logic [2:0]  m_address_a, state_dbg_a;
  logic [31:0] m_writedata_a, m_readdata_a;

  logic        job_start_b = 1'b0, m_waitrequest_b = 1'b0;
  logic        job_busy_b, job_done_b, job_timeout_b, m_read_b, m_write_b;
  logic [2:0]  m_address_b, state_dbg_b;
  logic [31:0] m_writedata_b, m_readdata_b;

  // Slave model state: number of busy polls to answer before reporting idle.
  int busy_polls_a = 0, rd_base_a = 0, busy_polls_b = 0, rd_base_b = 0;
  int rd_cnt_a = 0, done_cnt_a = 0, timeout_cnt_a = 0, overlap_a = 0, done_busy_a = 0;
  int rd_cnt_b = 0;
  logic [2:0]  wr_addr_a[$];
  logic [31:0] wr_data_a[$];
  logic [31:0] exp_q[$];

  assign m_readdata_a = {31'd0, ((rd_cnt_a - rd_base_a) < busy_polls_a)};
  assign m_readdata_b = {31'd0, ((rd_cnt_b - rd_base_b) < busy_polls_b)};

  // Clock / reset block.
  always #5 clk = ~clk;

  conv_job_launcher #(.POLL_GAP(3), .MAX_POLLS(4), .START_GAP(2)) dut_a (
    .clk(clk), .reset(rst), .job_start(job_start_a),
    .job_in_base(job_in_base), .job_flt_base(job_flt_base), .job_out_base(job_out_base),
    .job_depth(job_depth), .job_nfilt(job_nfilt), .job_width(job_width),
    .job_busy(job_busy_a), .job_done(job_done_a), .job_timeout(job_timeout_a),
    .m_address(m_address_a), .m_read(m_read_a), .m_write(m_write_a),
    .m_writedata(m_writedata_a), .m_readdata(m_readdata_a),
    .m_waitrequest(m_waitrequest_a), .state_dbg(state_dbg_a)
  );

  conv_job_launcher #(.POLL_GAP(0), .MAX_POLLS(0), .START_GAP(0)) dut_b (
    .clk(clk), .reset(rst), .job_start(job_start_b),
    .job_in_base(job_in_base), .job_flt_base(job_flt_base), .job_out_base(job_out_base),
    .job_depth(job_depth), .job_nfilt(job_nfilt), .job_width(job_width),
    .job_busy(job_busy_b), .job_done(job_done_b), .job_timeout(job_timeout_b),
    .m_address(m_address_b), .m_read(m_read_b), .m_write(m_write_b),
    .m_writedata(m_writedata_b), .m_readdata(m_readdata_b),
    .m_waitrequest(m_waitrequest_b), .state_dbg(state_dbg_b)
  );

  // Bus monitor: logs accepted transfers and counts pulses.
  always @(posedge clk) begin
    if (m_write_a && !m_waitrequest_a) begin
      wr_addr_a.push_back(m_address_a);
      wr_data_a.push_back(m_writedata_a);
    end
    if (m_read_a && !m_waitrequest_a) rd_cnt_a <= rd_cnt_a + 1;
    if (m_read_a && m_write_a) overlap_a <= overlap_a + 1;
    if (job_done_a) done_cnt_a <= done_cnt_a + 1;
    if (job_timeout_a) timeout_cnt_a <= timeout_cnt_a + 1;
    if (job_done_a && job_busy_a) done_busy_a <= done_busy_a + 1;
    if (m_read_b && !m_waitrequest_b) rd_cnt_b <= rd_cnt_b + 1;
  end

  // Driver tasks.
  task automatic set_words(input logic [31:0] w1, w2, w3, w4, w5, w6);
    job_in_base = w1; job_flt_base = w2; job_out_base = w3;
    job_depth = w4; job_nfilt = w5; job_width = w6;
  endtask

  task automatic start_a(input logic [31:0] w1, w2, w3, w4, w5, w6);
    @(negedge clk);
    set_words(w1, w2, w3, w4, w5, w6);
    job_start_a = 1'b1;
    @(negedge clk);
    job_start_a = 1'b0;
  endtask

  task automatic start_b(input logic [31:0] w1, w2, w3, w4, w5, w6);
    @(negedge clk);
    set_words(w1, w2, w3, w4, w5, w6);
    job_start_b = 1'b1;
    @(negedge clk);
    job_start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (job_busy_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (job_busy_a !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_a: job_busy still %b after %0d cycles, expected 0", job_busy_a, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({job_busy_a, job_done_a, job_timeout_a, m_read_a, m_write_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b expected 00000",
               {job_busy_a, job_done_a, job_timeout_a, m_read_a, m_write_a});
    end
    checks++;
    if ({m_address_a, m_writedata_a, state_dbg_a} !== 38'd0) begin
      errors++;
      $display("FAIL reset_bus_a: addr %0d data %0h state %0d expected 0", m_address_a, m_writedata_a, state_dbg_a);
    end
    checks++;
    if ({job_busy_b, job_done_b, job_timeout_b, m_read_b, m_write_b, m_address_b, m_writedata_b, state_dbg_b} !== 43'd0) begin
      errors++;
      $display("FAIL reset_b: outputs not all zero (busy %b write %b read %b state %0d)",
               job_busy_b, m_write_b, m_read_b, state_dbg_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int wb = wr_addr_a.size();
    int db = done_cnt_a;
    int tb0 = timeout_cnt_a;
    logic [2:0] ea;
    busy_polls_a = 3;
    rd_base_a = rd_cnt_a;
    exp_q = '{32'd1, 32'd128, 32'd256, 32'd3, 32'd2, 32'd6, 32'd0};
    start_a(1, 128, 256, 3, 2, 6);
    // Changing the inputs mid-job must not alter the data written.
    set_words(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006);
    checks++;
    if (job_busy_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", job_busy_a);
    end
    for (int k = 1; k <= 7; k++) begin
      ea = (k == 7) ? 3'd0 : 3'(k);
      checks++;
      if (m_write_a !== 1'b1 || m_read_a !== 1'b0 || m_address_a !== ea || m_writedata_a !== exp_q[k-1]) begin
        errors++;
        $display("FAIL basic_write%0d: wr %b addr %0d data %0d expected wr 1 addr %0d data %0d",
                 k, m_write_a, m_address_a, m_writedata_a, ea, exp_q[k-1]);
      end
      @(negedge clk);
    end
    checks++;
    if (m_write_a !== 1'b0 || m_read_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_gap_idle: wr %b rd %b expected 0 0", m_write_a, m_read_a);
    end
    wait_idle_a(200);
    checks++;
    if (rd_cnt_a - rd_base_a !== 4) begin
      errors++;
      $display("FAIL basic_reads: got %0d expected 4", rd_cnt_a - rd_base_a);
    end
    checks++;
    if (done_cnt_a - db !== 1 || timeout_cnt_a - tb0 !== 0) begin
      errors++;
      $display("FAIL basic_pulses: done %0d timeout %0d expected 1 0", done_cnt_a - db, timeout_cnt_a - tb0);
    end
    checks++;
    if (wr_addr_a.size() - wb !== 7) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d expected 7", wr_addr_a.size() - wb);
    end
    checks++;
    if (overlap_a !== 0 || done_busy_a !== 0) begin
      errors++;
      $display("FAIL basic_rules: rd+wr overlap %0d done-with-busy %0d expected 0 0", overlap_a, done_busy_a);
    end
  endtask

  task automatic test_stall;
    int wb = wr_addr_a.size();
    int cfg = 0, stalls = 0, a3 = 0;
    bit go_seen = 0;
    busy_polls_a = 0;
    rd_base_a = rd_cnt_a;
    start_a(1, 128, 256, 3, 2, 6);
    for (int i = 0; i < 40 && !go_seen; i++) begin
      if (m_write_a && m_address_a == 3'd0) begin
        go_seen = 1;
      end else begin
        if (m_write_a) cfg++;
        if (m_write_a && m_address_a == 3'd3) begin
          a3++;
          checks++;
          if (m_writedata_a !== 32'd256) begin
            errors++;
            $display("FAIL stall_data: got %0d expected 256", m_writedata_a);
          end
          if (stalls < 3) begin
            m_waitrequest_a = 1'b1;
            stalls++;
          end else begin
            m_waitrequest_a = 1'b0;
          end
        end else begin
          m_waitrequest_a = 1'b0;
        end
        @(negedge clk);
      end
    end
    m_waitrequest_a = 1'b0;
    checks++;
    if (go_seen !== 1'b1) begin
      errors++;
      $display("FAIL stall_go: start write not seen, got %b expected 1", go_seen);
    end
    checks++;
    if (cfg !== 9 || a3 !== 4) begin
      errors++;
      $display("FAIL stall_cfg_time: cfg %0d addr3 cycles %0d expected 9 4", cfg, a3);
    end
    wait_idle_a(200);
    checks++;
    if (wr_addr_a.size() - wb !== 7) begin
      errors++;
      $display("FAIL stall_wr_count: got %0d expected 7", wr_addr_a.size() - wb);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (wr_addr_a[wb+k] !== ((k == 6) ? 3'd0 : 3'(k + 1))) begin
          errors++;
          $display("FAIL stall_wr_addr%0d: got %0d expected %0d", k, wr_addr_a[wb+k], (k == 6) ? 0 : k + 1);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int db = done_cnt_a;
    int tb0 = timeout_cnt_a;
    busy_polls_a = 1000;
    rd_base_a = rd_cnt_a;
    start_a(7, 8, 9, 3, 1, 5);
    wait_idle_a(300);
    checks++;
    if (rd_cnt_a - rd_base_a !== 4) begin
      errors++;
      $display("FAIL timeout_reads: got %0d expected 4", rd_cnt_a - rd_base_a);
    end
    checks++;
    if (timeout_cnt_a - tb0 !== 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d expected 1", timeout_cnt_a - tb0);
    end
    checks++;
    if (done_cnt_a - db !== 0) begin
      errors++;
      $display("FAIL timeout_no_done: got %0d expected 0", done_cnt_a - db);
    end
  endtask

  task automatic test_ignore_start;
    int wb = wr_addr_a.size();
    int db = done_cnt_a;
    int n = 0;
    busy_polls_a = 3;
    rd_base_a = rd_cnt_a;
    exp_q = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd0};
    start_a(5, 6, 7, 8, 9, 10);
    while (!m_read_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_read_a !== 1'b1) begin
      errors++;
      $display("FAIL ignore_poll_seen: m_read %b expected 1", m_read_a);
    end
    set_words(99, 98, 97, 96, 95, 94);
    job_start_a = 1'b1;
    @(negedge clk);
    job_start_a = 1'b0;
    wait_idle_a(200);
    repeat (3) @(negedge clk);
    checks++;
    if (job_busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: got %b expected 0", job_busy_a);
    end
    checks++;
    if (done_cnt_a - db !== 1 || rd_cnt_a - rd_base_a !== 4) begin
      errors++;
      $display("FAIL ignore_done: done %0d reads %0d expected 1 4", done_cnt_a - db, rd_cnt_a - rd_base_a);
    end
    checks++;
    if (wr_addr_a.size() - wb !== 7) begin
      errors++;
      $display("FAIL ignore_wr_count: got %0d expected 7", wr_addr_a.size() - wb);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (wr_data_a[wb+k] !== exp_q[k]) begin
          errors++;
          $display("FAIL ignore_wr_data%0d: got %0d expected %0d", k, wr_data_a[wb+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int wb;
    int n = 0;
    busy_polls_a = 0;
    rd_base_a = rd_cnt_a;
    start_a(1, 128, 256, 3, 2, 6);
    while (!(m_write_a && m_address_a == 3'd4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_address_a !== 3'd4) begin
      errors++;
      $display("FAIL rstmid_reach: addr %0d expected 4", m_address_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_write_a !== 1'b0 || job_busy_a !== 1'b0 || state_dbg_a !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_abort: wr %b busy %b state %0d expected 0 0 0", m_write_a, job_busy_a, state_dbg_a);
    end
    @(negedge clk);
    rst = 1'b0;
    wb = wr_addr_a.size();
    start_a(11, 22, 33, 44, 55, 66);
    checks++;
    if (m_write_a !== 1'b1 || m_address_a !== 3'd1 || m_writedata_a !== 32'd11) begin
      errors++;
      $display("FAIL rstmid_restart: wr %b addr %0d data %0d expected 1 1 11", m_write_a, m_address_a, m_writedata_a);
    end
    wait_idle_a(200);
    checks++;
    if (wr_addr_a.size() - wb !== 7) begin
      errors++;
      $display("FAIL rstmid_wr_count: got %0d expected 7", wr_addr_a.size() - wb);
    end
  endtask

  task automatic test_zero_gap;
    int n = 0;
    busy_polls_b = 0;
    rd_base_b = rd_cnt_b;
    start_b(3, 4, 5, 3, 1, 8);
    while (!(m_write_b && m_address_b == 3'd0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_write_b !== 1'b1 || m_address_b !== 3'd0) begin
      errors++;
      $display("FAIL zgap_go: wr %b addr %0d expected 1 0", m_write_b, m_address_b);
    end
    @(negedge clk);
    checks++;
    if (m_write_b !== 1'b0 || m_read_b !== 1'b0) begin
      errors++;
      $display("FAIL zgap_gap_idle: wr %b rd %b expected 0 0", m_write_b, m_read_b);
    end
    @(negedge clk);
    checks++;
    if (m_read_b !== 1'b1 || m_address_b !== 3'd0) begin
      errors++;
      $display("FAIL zgap_read: rd %b addr %0d expected 1 0", m_read_b, m_address_b);
    end
    // Held start across the last poll and the done cycle must be ignored.
    job_start_b = 1'b1;
    @(negedge clk);
    checks++;
    if (job_done_b !== 1'b1 || job_busy_b !== 1'b0) begin
      errors++;
      $display("FAIL zgap_done: done %b busy %b expected 1 0", job_done_b, job_busy_b);
    end
    @(negedge clk);
    job_start_b = 1'b0;
    checks++;
    if (job_done_b !== 1'b0 || job_busy_b !== 1'b0) begin
      errors++;
      $display("FAIL zgap_start_in_done: done %b busy %b expected 0 0", job_done_b, job_busy_b);
    end
    @(negedge clk);
    checks++;
    if (job_busy_b !== 1'b0 || rd_cnt_b - rd_base_b !== 1) begin
      errors++;
      $display("FAIL zgap_after: busy %b reads %0d expected 0 1", job_busy_b, rd_cnt_b - rd_base_b);
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_timeout;
    test_ignore_start;
    test_reset_mid;
    test_zero_gap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
